// File: rtl/dpi_sched_pkg.sv
// Shared types and defaults for the DFA flow scheduler: FSM encoding and
// default channel, burst and engine-state widths.
package dpi_sched_pkg;

  localparam int NUM_CH_DEF    = 4;
  localparam int STATE_W_DEF   = 11;
  localparam int BURST_MAX_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESTORE = 2'd1,
    ST_RUN     = 2'd2,
    ST_SAVE    = 2'd3
  } sched_state_e;

endpackage

// File: rtl/dpi_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index strictly after the
// last granted one, wrapping; the pointer moves only when advance_i is high.
module dpi_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              advance_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  grant_idx_o
);

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    cand        = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_CH);
      if (req_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

  always_comb begin
    last_d = advance_i ? grant_idx_o : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= IDX_W'(NUM_CH - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/dpi_flow_scheduler.sv
// Time-multiplexes one DFA engine across NUM_CH byte channels by restoring a
// per-channel context, streaming a burst of bytes, then saving the context.
module dpi_flow_scheduler
  import dpi_sched_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int STATE_W   = STATE_W_DEF,
  localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int BW       = $clog2(BURST_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [8*NUM_CH-1:0] ch_data,
  input  logic [NUM_CH-1:0]   ch_vld,
  input  logic [NUM_CH-1:0]   ch_sop,
  input  logic [NUM_CH-1:0]   ch_eop,
  output logic [NUM_CH-1:0]   ch_rdy,
  output logic [7:0]          eng_char_in,
  output logic                eng_char_in_vld,
  output logic [STATE_W-1:0]  eng_state_in,
  output logic                eng_state_in_vld,
  input  logic [STATE_W-1:0]  eng_state_out,
  input  logic                eng_accept_out,
  output logic                match_vld,
  output logic [IDX_W-1:0]    match_ch,
  output logic                match_eop,
  output logic                busy,
  output sched_state_e        dbg_state
);

  // Handshake: a channel byte transfers in a cycle where ch_vld[i] & ch_rdy[i];
  // ch_rdy never depends on anything but the granted channel's vld/sop.
  sched_state_e       state_q, state_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic               last_eop_q, last_eop_d;
  logic [STATE_W-1:0] ctx_q [NUM_CH];
  logic               match_vld_q, match_eop_q;
  logic [IDX_W-1:0]   match_ch_q;

  logic [NUM_CH-1:0]  arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_adv;
  logic               vld_g, sop_g, eop_g, mid_sop, take, hit;
  logic [7:0]         data_g;

  dpi_rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (ch_vld),
    .advance_i   (arb_adv),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx)
  );

  always_comb begin
    data_g = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (g_q == IDX_W'(i)) data_g = ch_data[8*i +: 8];
    end
  end

  assign vld_g   = ch_vld[g_q];
  assign sop_g   = ch_sop[g_q];
  assign eop_g   = ch_eop[g_q];
  // A packet start after the first byte of a grant belongs to the next grant.
  assign mid_sop = sop_g && (burst_q != '0);
  assign take    = (state_q == ST_RUN) && vld_g && !mid_sop;
  assign hit     = take && eng_accept_out;
  assign arb_adv = (state_q == ST_IDLE) && (|arb_grant);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (arb_adv) state_d = ST_RESTORE;
      ST_RESTORE: state_d = ST_RUN;
      ST_RUN:     if (!take || eop_g || (burst_q == BW'(BURST_MAX - 1))) state_d = ST_SAVE;
      ST_SAVE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ch_rdy           = '0;
    eng_char_in      = '0;
    eng_char_in_vld  = 1'b0;
    eng_state_in     = '0;
    eng_state_in_vld = 1'b0;
    if (state_q == ST_RESTORE) begin
      eng_state_in_vld = 1'b1;
      eng_state_in     = sop_g ? '0 : ctx_q[g_q];
    end
    if (take) begin
      ch_rdy[g_q]     = 1'b1;
      eng_char_in_vld = 1'b1;
      eng_char_in     = data_g;
    end
  end

  always_comb begin
    g_d        = g_q;
    burst_d    = burst_q;
    last_eop_d = last_eop_q;
    if (arb_adv) begin
      g_d        = arb_idx;
      burst_d    = '0;
      last_eop_d = 1'b0;
    end else if (take) begin
      burst_d    = burst_q + BW'(1);
      last_eop_d = eop_g;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q         <= '0;
      burst_q     <= '0;
      last_eop_q  <= 1'b0;
      match_vld_q <= 1'b0;
      match_ch_q  <= '0;
      match_eop_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) ctx_q[i] <= '0;
    end else begin
      g_q         <= g_d;
      burst_q     <= burst_d;
      last_eop_q  <= last_eop_d;
      match_vld_q <= hit;
      match_ch_q  <= hit ? g_q : '0;
      match_eop_q <= hit && eop_g;
      // A packet that ended inside this grant leaves a fresh context behind.
      if (state_q == ST_SAVE) ctx_q[g_q] <= last_eop_q ? '0 : eng_state_out;
    end
  end

  assign match_vld = match_vld_q;
  assign match_ch  = match_ch_q;
  assign match_eop = match_eop_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dpi_flow_scheduler.sv
// Bench for dpi_flow_scheduler: channel byte queues as sources, a toy DFA
// engine, and a grant-level plan model checked against the DUT every cycle.
module tb_dpi_flow_scheduler;
  import dpi_sched_pkg::*;

  localparam int N  = 4;
  localparam int W  = 11;
  localparam int BM = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } byte_t;

  typedef struct packed {
    logic [1:0]   st;
    logic         busy;
    logic [N-1:0] rdy;
    logic         cvld;
    logic [7:0]   ch;
    logic         svld;
    logic [W-1:0] sin;
    logic         mvld;
    logic [1:0]   mch;
    logic         meop;
  } rec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [8*N-1:0] ch_data;
  logic [N-1:0]   ch_vld, ch_sop, ch_eop, ch_rdy;
  logic [7:0]     eng_char_in;
  logic           eng_char_in_vld;
  logic [W-1:0]   eng_state_in;
  logic           eng_state_in_vld;
  logic [W-1:0]   eng_state_out;
  logic           eng_accept_out;
  logic           match_vld;
  logic [1:0]     match_ch;
  logic           match_eop;
  logic           busy;
  sched_state_e   dbg_state;

  dpi_flow_scheduler #(.NUM_CH(N), .BURST_MAX(BM), .STATE_W(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .ch_data          (ch_data),
    .ch_vld           (ch_vld),
    .ch_sop           (ch_sop),
    .ch_eop           (ch_eop),
    .ch_rdy           (ch_rdy),
    .eng_char_in      (eng_char_in),
    .eng_char_in_vld  (eng_char_in_vld),
    .eng_state_in     (eng_state_in),
    .eng_state_in_vld (eng_state_in_vld),
    .eng_state_out    (eng_state_out),
    .eng_accept_out   (eng_accept_out),
    .match_vld        (match_vld),
    .match_ch         (match_ch),
    .match_eop        (match_eop),
    .busy             (busy),
    .dbg_state        (dbg_state)
  );

  // ---------------- toy DFA engine ----------------
  function automatic logic [W-1:0] eng_f(logic [W-1:0] s, logic [7:0] c);
    return W'(s * W'(3) + W'(c));
  endfunction

  logic [W-1:0] eng_q;
  always @(posedge clk) begin
    if (rst)                   eng_q <= '0;
    else if (eng_state_in_vld) eng_q <= eng_state_in;
    else if (eng_char_in_vld)  eng_q <= eng_f(eng_q, eng_char_in);
  end
  assign eng_state_out  = eng_q;
  assign eng_accept_out = eng_char_in_vld && (eng_char_in == 8'hA5);

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  byte_t        chq [N][$];
  rec_t         plan[$];
  logic [W-1:0] mctx [N];
  int           mptr;
  logic [N-1:0] pop_mask = '0;
  int           busy_cnt;
  int           grant_log[$];
  int           cnt_log[$];
  logic [W-1:0] restore_log[$];
  logic [2:0]   match_log[$];
  rec_t         exp_r, obs_r;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic any_req();
    logic r;
    r = 1'b0;
    for (int i = 0; i < N; i++) if (chq[i].size() > 0) r = 1'b1;
    return r;
  endfunction

  function automatic rec_t observe();
    rec_t o;
    o.st = dbg_state;  o.busy = busy;  o.rdy = ch_rdy;
    o.cvld = eng_char_in_vld;  o.ch = eng_char_in;
    o.svld = eng_state_in_vld; o.sin = eng_state_in;
    o.mvld = match_vld; o.mch = match_ch; o.meop = match_eop;
    return o;
  endfunction

  // Plan a whole grant from the channel queue: restore, bytes, optional stall, save.
  function automatic void build_plan();
    int g, n;
    logic [W-1:0] s, rv;
    logic last_eop, pend, pend_eop, done;
    rec_t r;
    byte_t b;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (mptr + k) % N;
      if (g < 0 && chq[c].size() > 0) g = c;
    end
    mptr = g;
    rv = chq[g][0].sop ? '0 : mctx[g];
    r = '0; r.st = ST_RESTORE; r.busy = 1'b1; r.svld = 1'b1; r.sin = rv;
    plan.push_back(r);
    s = rv; n = 0; last_eop = 1'b0; pend = 1'b0; pend_eop = 1'b0; done = 1'b0;
    while (!done) begin
      r = '0; r.st = ST_RUN; r.busy = 1'b1;
      if (pend) begin r.mvld = 1'b1; r.mch = 2'(g); r.meop = pend_eop; pend = 1'b0; end
      if (n == chq[g].size() || (n > 0 && chq[g][n].sop)) begin
        plan.push_back(r);
        done = 1'b1;
      end else begin
        b = chq[g][n];
        r.rdy = N'(1) << g; r.cvld = 1'b1; r.ch = b.d;
        plan.push_back(r);
        s = eng_f(s, b.d); last_eop = b.eop; n++;
        pend = (b.d == 8'hA5); pend_eop = b.eop;
        if (b.eop || n == BM) done = 1'b1;
      end
    end
    r = '0; r.st = ST_SAVE; r.busy = 1'b1;
    if (pend) begin r.mvld = 1'b1; r.mch = 2'(g); r.meop = pend_eop; end
    plan.push_back(r);
    mctx[g] = last_eop ? '0 : s;
    grant_log.push_back(g);
    cnt_log.push_back(n);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      plan.delete();
      for (int i = 0; i < N; i++) mctx[i] = '0;
      mptr = N - 1;
      pop_mask = '0;
    end else begin
      if (plan.size() == 0) begin
        exp_r = '0; exp_r.st = ST_IDLE;
        if (any_req()) build_plan();
      end else begin
        exp_r = plan.pop_front();
      end
      obs_r = observe();
      check("cycle", 64'(obs_r), 64'(exp_r));
      pop_mask = ch_rdy;
      if (busy) busy_cnt++;
      if (eng_state_in_vld) restore_log.push_back(eng_state_in);
      if (match_vld) match_log.push_back({match_ch, match_eop});
    end
  end

  // ---------------- driver tasks ----------------
  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      if (chq[i].size() > 0) begin
        ch_vld[i] = 1'b1; ch_data[8*i +: 8] = chq[i][0].d;
        ch_sop[i] = chq[i][0].sop; ch_eop[i] = chq[i][0].eop;
      end else begin
        ch_vld[i] = 1'b0; ch_data[8*i +: 8] = 8'h00;
        ch_sop[i] = 1'b0; ch_eop[i] = 1'b0;
      end
    end
  endfunction

  task automatic tick();
    byte_t tmp;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (pop_mask[i] && chq[i].size() > 0) tmp = chq[i].pop_front();
    end
    drive();
  endtask

  task automatic push(int c, logic [7:0] d, logic sop, logic eop);
    byte_t b;
    b.d = d; b.sop = sop; b.eop = eop;
    chq[c].push_back(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) chq[i].delete();
    drive();
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    grant_log.delete(); cnt_log.delete(); restore_log.delete(); match_log.delete();
    busy_cnt = 0;
  endtask

  task automatic run_until_idle(int budget);
    int n;
    n = 0;
    drive();
    while ((any_req() || plan.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("idle_reached", 64'(n < budget), 64'(1));
    tick();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive();
    repeat (3) tick();
    rst = 1'b0;
    check("reset_outputs", 64'(observe()), 64'(0));

    // Single 3-byte packet on channel 0.
    clear_logs();
    push(0, 8'h01, 1'b1, 1'b0);
    push(0, 8'h02, 1'b0, 1'b0);
    push(0, 8'h03, 1'b0, 1'b1);
    run_until_idle(50);
    check("t40_busy_cycles", 64'(busy_cnt), 64'(5));
    check("t40_restore0", 64'(restore_log.size() > 0 ? restore_log[0] : 11'h7ff), 64'(0));
    check("t40_bytes", 64'(cnt_log.size() > 0 ? cnt_log[0] : -1), 64'(3));
    check("t40_ctx_saved", 64'(mctx[0]), 64'(0));

    // All channels streaming 40 bytes, no eop.
    do_reset();
    clear_logs();
    for (int c = 0; c < N; c++)
      for (int k = 0; k < 40; k++) push(c, 8'(c * 40 + k + 1), k == 0, 1'b0);
    run_until_idle(1000);
    check("t41_ngrants", 64'(grant_log.size()), 64'(12));
    if (grant_log.size() >= 9) begin
      check("t41_g0", 64'(grant_log[0]), 64'(0));
      check("t41_g1", 64'(grant_log[1]), 64'(1));
      check("t41_g2", 64'(grant_log[2]), 64'(2));
      check("t41_g3", 64'(grant_log[3]), 64'(3));
      check("t41_g4", 64'(grant_log[4]), 64'(0));
      check("t41_n0", 64'(cnt_log[0]), 64'(16));
      check("t41_n4", 64'(cnt_log[4]), 64'(16));
      check("t41_n8", 64'(cnt_log[8]), 64'(8));
    end

    // Channel 2: 5 bytes then a gap, resumed later.
    clear_logs();
    push(2, 8'h10, 1'b1, 1'b0);
    push(2, 8'h20, 1'b0, 1'b0);
    push(2, 8'h30, 1'b0, 1'b0);
    push(2, 8'h40, 1'b0, 1'b0);
    push(2, 8'h50, 1'b0, 1'b0);
    run_until_idle(50);
    check("t42_ctx2_model", 64'(mctx[2]), 64'(816));
    repeat (5) tick();
    push(2, 8'h60, 1'b0, 1'b0);
    push(2, 8'h70, 1'b0, 1'b1);
    run_until_idle(50);
    check("t42_restore", 64'(restore_log.size() > 1 ? restore_log[1] : 11'h7ff), 64'(816));

    // Channel 1: accept on byte 4, then a packet whose eop byte matches.
    clear_logs();
    push(1, 8'h01, 1'b1, 1'b0);
    push(1, 8'h02, 1'b0, 1'b0);
    push(1, 8'h03, 1'b0, 1'b0);
    push(1, 8'hA5, 1'b0, 1'b0);
    push(1, 8'h05, 1'b0, 1'b1);
    push(1, 8'h11, 1'b1, 1'b0);
    push(1, 8'hA5, 1'b0, 1'b1);
    run_until_idle(60);
    check("t43_nmatch", 64'(match_log.size()), 64'(2));
    check("t43_match0", 64'(match_log.size() > 0 ? match_log[0] : 3'b111), 64'(3'b010));
    check("t43_match1", 64'(match_log.size() > 1 ? match_log[1] : 3'b000), 64'(3'b011));

    // Reset during RUN on channel 3.
    clear_logs();
    for (int k = 0; k < 20; k++) push(3, 8'(8'h80 + k), k == 0, 1'b0);
    drive();
    repeat (5) tick();
    do_reset();
    check("t44_post_reset", 64'(observe()), 64'(0));
    clear_logs();
    push(3, 8'h21, 1'b0, 1'b0);
    push(3, 8'h22, 1'b0, 1'b1);
    run_until_idle(50);
    check("t44_restore", 64'(restore_log.size() > 0 ? restore_log[0] : 11'h7ff), 64'(0));

    // Mid-grant sop on channel 0.
    clear_logs();
    push(0, 8'h01, 1'b1, 1'b0);
    push(0, 8'h02, 1'b0, 1'b0);
    push(0, 8'h03, 1'b1, 1'b0);
    push(0, 8'h04, 1'b0, 1'b1);
    run_until_idle(60);
    check("t45_ngrants", 64'(grant_log.size()), 64'(2));
    check("t45_n0", 64'(cnt_log.size() > 0 ? cnt_log[0] : -1), 64'(2));
    check("t45_restore1", 64'(restore_log.size() > 1 ? restore_log[1] : 11'h7ff), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
